instruction_memory_loader: RTL and testbench
============================================

Name: instruction_memory_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream and writes 32-bit words into the memory's write port.
- Words are written to byte addresses 0, 4, 8, … and the memory indexes them by address[31:2].
- Holds the CPU in reset while loading.
- Sits between the host byte link (UART/JTAG bridge) and the instruction memory write port.

Parameters:
- DEPTH, 256, number of 32-bit words in the instruction memory.
- COUNT_WIDTH, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  single-cycle pulse; begins a load session.
- byteValid  input  1  host has a byte on byteData.
- byteData  input  8  stream byte.
- byteReady  output  1  loader accepts byteData this cycle.
- memWriteEnable  output  1  write strobe to instruction memory.
- memWriteAddress  output  32  byte address, word aligned (bits [1:0] = 0).
- memWriteData  output  32  assembled instruction word.
- cpuHold  output  1  keeps the CPU in reset during the session.
- done  output  1  load completed successfully; level output.
- error  output  1  header count exceeded DEPTH; level output.
- wordsWritten  output  COUNT_WIDTH  number of words committed in this session.

Behaviour:
- Reset (asynchronous) values: state IDLE; byteReady=0, memWriteEnable=0, memWriteAddress=0, memWriteData=0, cpuHold=0, done=0, error=0, wordsWritten=0.
- Byte transfer occurs on a clock edge where byteValid && byteReady.
- Stream format, big-endian:
  - count[15:8], then count[7:0].
  - Then 4*count bytes, each word sent MSB first.
- State machine:
  - IDLE: byteReady=0. On start → HEADER_HI; clear done, error, wordsWritten, byte counter and address; set cpuHold=1.
  - HEADER_HI: byteReady=1. On transfer, latch count high byte → HEADER_LO.
  - HEADER_LO: byteReady=1. On transfer, latch count low byte and evaluate the full count:
    - count==0 → DONE.
    - count>DEPTH → ERROR.
    - otherwise → DATA.
  - DATA: byteReady=1. On transfer, shift the byte into the word register (new byte enters [7:0]); the 2-bit byte counter increments. On the 4th byte → WRITE.
  - WRITE: exactly one cycle.
    - byteReady=0, memWriteEnable=1, memWriteData=assembled word, memWriteAddress=current address.
    - Next cycle: address += 4, wordsWritten += 1.
    - If wordsWritten+1 == count → DONE, else → DATA.
  - DONE: done=1, cpuHold=0, byteReady=0. start → HEADER_HI (new session).
  - ERROR: error=1, cpuHold=0, byteReady=0, no writes. start → HEADER_HI.
- Latency:
  - The write strobe asserts in the cycle after the 4th byte of a word is accepted.
  - done asserts in the cycle after the final WRITE.
- memWriteEnable is high only in WRITE. memWriteAddress and memWriteData are registered and hold their values between writes.
- start while in HEADER_HI, HEADER_LO, DATA or WRITE is ignored.
- byteValid outside the accepting states is ignored; the byte is not consumed.
- Address width: a 32-bit counter. count ≤ DEPTH guarantees the maximum address is 4*(DEPTH-1); there is no wrap.
- count==DEPTH is legal: the last address is 4*(DEPTH-1).
- Reset mid-session: returns immediately to IDLE with reset values. Partially written memory contents are left as-is; cpuHold drops to 0.
- The host may deassert byteValid at any point. The loader waits indefinitely, with no timeout.

Decomposition:
- Shared package `loader_pkg`:
  - enum loader_state_t {IDLE, HEADER_HI, HEADER_LO, DATA, WRITE, DONE, ERROR}.
  - Constants BYTES_PER_WORD=4, WORD_ADDR_STEP=4.
- One natural sub-module, `byte_word_assembler`:
  - Shift register plus 2-bit counter; outputs word and wordComplete.
  - Clear input driven by the FSM on start.

Test Plan:
- Load 2 words: start, then bytes 00 02 | 20 08 00 05 | 00 00 00 0C, byteValid held high → exactly 2 write strobes:
  - (addr 0x0, data 0x20080005)
  - (addr 0x4, data 0x0000000C)
  - Then done=1, wordsWritten=2, cpuHold falls with done.
- Backpressure and gaps: same stream with byteValid low for 3 cycles between every byte → identical writes. byteReady=0 exactly in each WRITE cycle.
- Zero count: bytes 00 00 → no writes; done=1 two accepted-byte cycles after start; error=0.
- Overflow: DEPTH=256, header 01 01 (257) → error=1, done=0, no memWriteEnable, byteReady=0 afterwards.
- Full-depth load of 256 words (data = index) → last write is addr 0x3FC, data 0x000000FF; wordsWritten=256.
- Reset mid-word: after the 2nd data byte, pulse reset → all outputs at reset values. A new start with 00 01 AA BB CC DD writes 0xAABBCCDD at addr 0x0; no stale bytes are merged into the word.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state type and constants for the instruction memory loader
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HEADER_HI = 3'd1,
      HEADER_LO = 3'd2,
      DATA      = 3'd3,
      WRITE     = 3'd4,
      DONE      = 3'd5,
      ERROR     = 3'd6
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_ADDR_STEP = 4;

endpackage

// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - big-endian byte-to-word shift register with byte counter
module byte_word_assembler
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_complete_o
);

   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   logic [23:0] word_q;
   logic [1:0]  cnt_q;

   // The incoming byte is presented as the word's LSB so the caller can capture
   // the complete word on the same edge that accepts the 4th byte.
   assign word_o          = {word_q, byte_i};
   assign word_complete_o = shift_i && (cnt_q == LAST_BYTE);

   // Shift accepted bytes in MSB first; clear drops any partial word from a prior session.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (clear_i) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (shift_i) begin
         word_q <= word_o[23:0];
         cnt_q  <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/instruction_memory_loader.sv
// rtl/instruction_memory_loader.sv - loads a counted byte-stream program image into instruction memory
module instruction_memory_loader
   import loader_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   byteValid,
   input  logic [7:0]             byteData,
   output logic                   byteReady,
   output logic                   memWriteEnable,
   output logic [31:0]            memWriteAddress,
   output logic [31:0]            memWriteData,
   output logic                   cpuHold,
   output logic                   done,
   output logic                   error,
   output logic [COUNT_WIDTH-1:0] wordsWritten
);

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);
   localparam logic [31:0] STEP_U  = 32'(WORD_ADDR_STEP);

   loader_state_t          state_q, state_d;
   logic [7:0]             hdr_hi_q, hdr_hi_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] words_q, words_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;

   logic        transfer;
   logic        start_accept;
   logic        shift_en;
   logic [15:0] header;
   logic [31:0] asm_word;
   logic        asm_complete;

   assign byteReady    = (state_q == HEADER_HI) || (state_q == HEADER_LO) || (state_q == DATA);
   assign transfer     = byteValid && byteReady;
   assign start_accept = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
   assign shift_en     = transfer && (state_q == DATA);
   assign header       = {hdr_hi_q, byteData};

   assign memWriteEnable  = (state_q == WRITE);
   assign memWriteAddress = addr_q;
   assign memWriteData    = wdata_q;
   assign cpuHold         = byteReady || (state_q == WRITE);
   assign done            = (state_q == DONE);
   assign error           = (state_q == ERROR);
   assign wordsWritten    = words_q;

   byte_word_assembler u_asm (
      .clk_i           (clk),
      .rst_i           (reset),
      .clear_i         (start_accept),
      .shift_i         (shift_en),
      .byte_i          (byteData),
      .word_o          (asm_word),
      .word_complete_o (asm_complete)
   );

   // Session sequencing: header decode, word collection and one-cycle write strobe.
   always_comb begin
      state_d  = state_q;
      hdr_hi_d = hdr_hi_q;
      count_d  = count_q;
      words_d  = words_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d = HEADER_HI;
               words_d = '0;
               addr_d  = '0;
            end
         end
         HEADER_HI: begin
            if (transfer) begin
               hdr_hi_d = byteData;
               state_d  = HEADER_LO;
            end
         end
         HEADER_LO: begin
            if (transfer) begin
               count_d = COUNT_WIDTH'(header);
               if (header == 16'd0) begin
                  state_d = DONE;
               end else if (32'(header) > DEPTH_U) begin
                  state_d = ERROR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (asm_complete) begin
               wdata_d = asm_word;
               state_d = WRITE;
            end
         end
         WRITE: begin
            addr_d  = addr_q + STEP_U;
            words_d = words_q + 1'b1;
            state_d = (words_d == count_q) ? DONE : DATA;
         end
         default: state_d = IDLE;
      endcase
   end

   // Register all session state; reset abandons any session in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         hdr_hi_q <= '0;
         count_q  <= '0;
         words_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         hdr_hi_q <= hdr_hi_d;
         count_q  <= count_d;
         words_q  <= words_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// tb/tb_instruction_memory_loader.sv - randomized self-checking bench for the instruction memory loader
module tb_instruction_memory_loader;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        byteValid = 1'b0;
   logic [7:0]  byteData = 8'h00;
   logic        byteReady;
   logic        memWriteEnable;
   logic [31:0] memWriteAddress;
   logic [31:0] memWriteData;
   logic        cpuHold;
   logic        done;
   logic        error;
   logic [15:0] wordsWritten;

   int total = 0;
   int bad   = 0;

   logic [7:0]  stim[$];
   logic [63:0] exp_q[$];
   logic [31:0] last_addr, last_data;

   instruction_memory_loader #(.DEPTH(DEPTH), .COUNT_WIDTH(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .byteValid       (byteValid),
      .byteData        (byteData),
      .byteReady       (byteReady),
      .memWriteEnable  (memWriteEnable),
      .memWriteAddress (memWriteAddress),
      .memWriteData    (memWriteData),
      .cpuHold         (cpuHold),
      .done            (done),
      .error           (error),
      .wordsWritten    (wordsWritten)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Every write strobe must match the next write the model predicts.
   always @(negedge clk) begin
      if (!reset && memWriteEnable) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_write", memWriteAddress, 32'hFFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check_val("write_addr", memWriteAddress, e[63:32]);
            check_val("write_data", memWriteData, e[31:0]);
            check_val("ready_in_write", {31'd0, byteReady}, 32'd0);
         end
         last_addr = memWriteAddress;
         last_data = memWriteData;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
      int n;
      byteValid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         byteData = 8'($urandom);
         start = poke_start && ($urandom_range(1, 0) == 1);
         @(posedge clk); #1;
         start = 1'b0;
      end
      byteValid = 1'b1;
      byteData  = b;
      n = 0;
      while (!byteReady && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check_val("byte_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      byteValid = 1'b0;
   endtask

   // Reference: from the byte list alone derive the writes and the final status.
   task automatic run_load(input int max_gap, input bit poke_start);
      int cnt, nbytes;
      bit exp_err;
      cnt = {stim[0], stim[1]};
      exp_err = cnt > DEPTH;
      exp_q.delete();
      if (!exp_err) begin
         for (int i = 0; i < cnt; i++)
            exp_q.push_back({32'(4 * i), stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]});
      end
      nbytes = exp_err ? 2 : 2 + 4 * cnt;

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_val("start_hold", {31'd0, cpuHold}, 32'd1);
      check_val("start_done_clr", {30'd0, done, error}, 32'd0);
      check_val("start_words_clr", {16'd0, wordsWritten}, 32'd0);

      for (int i = 0; i < nbytes; i++)
         send_byte(stim[i], $urandom_range(max_gap, 0), poke_start);

      if (exp_err) begin
         check_val("ovf_error", {31'd0, error}, 32'd1);
         byteValid = 1'b1;
         for (int k = 0; k < 4; k++) begin
            check_val("ovf_ready", {31'd0, byteReady}, 32'd0);
            @(posedge clk); #1;
         end
         byteValid = 1'b0;
      end else if (cnt == 0) begin
         check_val("zero_done_now", {31'd0, done}, 32'd1);
      end else begin
         check_val("last_we", {31'd0, memWriteEnable}, 32'd1);
         check_val("done_before_write", {31'd0, done}, 32'd0);
         @(posedge clk); #1;
      end
      check_val("final_done", {31'd0, done}, {31'd0, !exp_err});
      check_val("final_error", {31'd0, error}, {31'd0, exp_err});
      check_val("final_hold", {31'd0, cpuHold}, 32'd0);
      check_val("final_words", {16'd0, wordsWritten}, exp_err ? 32'd0 : 32'(cnt));
      check_val("writes_left", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic load_words(input int cnt, input bit rnd);
      stim.delete();
      stim.push_back(8'(cnt >> 8));
      stim.push_back(8'(cnt));
      for (int i = 0; i < cnt && cnt <= DEPTH; i++) begin
         logic [31:0] w;
         w = rnd ? $urandom : 32'(i);
         stim.push_back(w[31:24]);
         stim.push_back(w[23:16]);
         stim.push_back(w[15:8]);
         stim.push_back(w[7:0]);
      end
   endtask

   initial begin
      #2;
      check_val("rst_ready", {31'd0, byteReady}, 32'd0);
      check_val("rst_we", {31'd0, memWriteEnable}, 32'd0);
      check_val("rst_addr", memWriteAddress, 32'd0);
      check_val("rst_data", memWriteData, 32'd0);
      check_val("rst_flags", {29'd0, cpuHold, done, error}, 32'd0);
      check_val("rst_words", {16'd0, wordsWritten}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
      run_load(0, 1'b0);
      run_load(3, 1'b0);

      stim = '{8'h00, 8'h00};
      run_load(0, 1'b0);

      stim = '{8'h01, 8'h01};
      run_load(0, 1'b0);

      load_words(DEPTH, 1'b0);
      run_load(0, 1'b0);
      check_val("full_last_addr", last_addr, 32'h0000_03FC);
      check_val("full_last_data", last_data, 32'h0000_00FF);

      for (int s = 0; s < 8; s++) begin
         if (s == 7) load_words($urandom_range(65535, DEPTH + 1), 1'b1);
         else load_words($urandom_range(20, 1), 1'b1);
         run_load(3, 1'b1);
      end

      stim = '{8'h00, 8'h01, 8'hAA, 8'hBB};
      exp_q.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(stim[i], 0, 1'b0);
      reset = 1'b1;
      #2;
      check_val("mid_rst_ready", {31'd0, byteReady}, 32'd0);
      check_val("mid_rst_we", {31'd0, memWriteEnable}, 32'd0);
      check_val("mid_rst_addr", memWriteAddress, 32'd0);
      check_val("mid_rst_data", memWriteData, 32'd0);
      check_val("mid_rst_flags", {29'd0, cpuHold, done, error}, 32'd0);
      check_val("mid_rst_words", {16'd0, wordsWritten}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      stim = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_load(1, 1'b0);
      check_val("post_rst_data", last_data, 32'hAABB_CCDD);
      check_val("post_rst_addr", last_addr, 32'h0000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
